variable_delay_estimator: RTL and testbench
===========================================

Name: variable_delay_estimator

Overview:
- Receiving-end counterpart of variable_delay_line: observes a reference stream and a delayed copy on a shared strobe, and recovers the integer delay (in strobes) between them.
- Used to calibrate or verify dynamic delay lines in DSP chains.
- Holds a DEPTH-entry reference history, searches candidate delays, and locks and tracks the matching one.

Parameters:
- WIDTH, 32, sample width in bits.
- DEPTH, 32, number of candidate delays, 0..DEPTH-1; DEPTH >= 2.
- DEFAULT_DATA, 0, history reset/fill value.
- LOCK_COUNT, 8, consecutive matches required to lock; >= 1.
- UNLOCK_COUNT, 4, consecutive mismatches while locked that drop lock; >= 1.

Ports:
- clk, input, 1, clock.
- reset_n, input, 1, asynchronous active-low reset.
- clk_en, input, 1, global enable; when low, all state holds.
- stb_in, input, 1, qualifies ref_in and dly_in on the same cycle.
- ref_in, input, WIDTH, reference (undelayed) sample.
- dly_in, input, WIDTH, delayed sample under test.
- restart, input, 1, synchronous request to drop lock and re-search from delay 0.
- searching, output, 1, high in the SEARCH state.
- locked, output, 1, high in the LOCKED state.
- delay_out, output, $clog2(DEPTH), locked delay estimate.
- lost, output, 1, one-cycle pulse when lock is lost.

Behaviour:
- Interface: one clock (clk). reset_n is asynchronous, active-low. All logic is clocked by clk.
- Reset values: searching=1, locked=0, delay_out=0, lost=0, cand=0, match_cnt=0, miss_cnt=0, fill_cnt=0, all history entries = DEFAULT_DATA.
- "Event" means clk_en=1 and stb_in=1 at a rising clk edge. No state or output changes except on events, the restart rule, and clearing lost.

History:
- On each event: hist[0] <= ref_in; hist[k] <= hist[k-1] for k = 1..DEPTH-2.
- fill_cnt increments on each event, saturating at DEPTH-1.

Candidate reference for delay d:
- d = 0: ref_in.
- Otherwise: hist[d-1], using the pre-shift value.

Match rule:
- match(d) = (dly_in == candidate reference for d) AND (fill_cnt >= d).
- fill_cnt is the pre-increment value.
- An unfilled history tap is always a mismatch, so DEFAULT_DATA never produces a false lock.

SEARCH (searching=1), on each event:
- On a match: match_cnt++.
  - If match_cnt reaches LOCK_COUNT: go to LOCKED, delay_out <= cand, miss_cnt <= 0.
- On a mismatch: match_cnt <= 0; cand <= (cand == DEPTH-1) ? 0 : cand+1.
  - cand wraps around to 0 after DEPTH-1.

LOCKED (locked=1), on each event, comparing at delay_out:
- On a match: miss_cnt <= 0.
- On a mismatch: miss_cnt++.
  - If miss_cnt reaches UNLOCK_COUNT: go to SEARCH, cand <= 0, match_cnt <= 0, and lost=1 for exactly one clk cycle.
- delay_out holds its last locked value while searching.

restart:
- When restart=1 and clk_en=1, go to SEARCH with cand, match_cnt and miss_cnt cleared. History and fill_cnt are kept.
- No lost pulse is generated.
- If an event occurs on the same cycle, restart wins; the sample is still shifted into history.

Latency: outputs are registered and become visible on the edge that samples the deciding event (one cycle after stb_in is presented).

Reset mid-operation: asynchronous return to the reset values, regardless of clk_en.

Decomposition:
- Package variable_delay_estimator_pkg:
  - state enum {SEARCH, LOCKED};
  - function for the delay width, $clog2(DEPTH).
- Sub-module delay_history_buf: holds the shift history, the fill counter and the candidate-tap mux (ports: tap select, tap data, tap valid). It uses the same async active-low reset.
- The top level holds the FSM and the counters.

Test Plan (DEPTH=32, LOCK_COUNT=8, UNLOCK_COUNT=4, ref = incrementing counter from 1):
- Reset:
  - stimulus: reset_n pulsed low, then released with no strobes;
  - response: searching=1, locked=0, delay_out=0, lost=0, all held over 100 cycles.
- Basic lock:
  - stimulus: dly_in = ref delayed by 5 strobes, stb every cycle;
  - response: locked rises with delay_out=5 within 5+8+1 strobes; searching falls on the same edge.
- Boundaries:
  - stimulus: delay 0 (dly_in = ref_in), then a separate run with delay 31;
  - response: locks at 0 and at 31 respectively; a delay of 32 never locks and cand wraps from 31 to 0.
- Relock:
  - stimulus: locked at 5, source delay switched to 9;
  - response: after 4 mismatching strobes, lost=1 for one cycle and locked=0, then relock with delay_out=9.
- Glitch tolerance:
  - stimulus: locked at 5, corrupt one dly_in sample, or 3 consecutive samples;
  - response: locked stays 1, lost stays 0; the 4th consecutive bad sample drops lock.
- Gaps, restart and reset while locked:
  - stimulus: random stb_in gaps and clk_en low periods;
  - response: the lock result is identical to gap-free operation.
  - stimulus: restart while locked;
  - response: searching=1 next cycle, no lost pulse, relocks at the same delay.
  - stimulus: reset_n low mid-lock;
  - response: all outputs immediately return to their reset values.

Source files
------------

// File: rtl/variable_delay_estimator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : variable_delay_estimator_pkg
// Description : Shared types and helpers for the variable delay estimator.
// Revision    : 1.0 - initial release
// ============================================================================
package variable_delay_estimator_pkg;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic int delay_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/variable_delay_estimator_history.sv
`default_nettype none
// ============================================================================
// Module      : delay_history_buf
// Description : Reference sample history, fill counter and candidate-tap mux.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_history_buf
    import variable_delay_estimator_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               DEPTH        = 32,
    parameter logic [WIDTH-1:0] DEFAULT_DATA = '0,
    localparam int              AW           = delay_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_shift_en,
    input  logic [WIDTH-1:0] i_ref,
    input  logic [AW-1:0]    i_tap_sel,
    output logic [WIDTH-1:0] o_tap_data,
    output logic             o_tap_valid
);

    localparam logic [AW-1:0] c_fill_max = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_hist [DEPTH-1];
    logic [AW-1:0]    r_fill;
    logic [AW-1:0]    w_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                r_hist[k] <= DEFAULT_DATA;
            end
            r_fill <= '0;
        end else if (i_shift_en) begin
            r_hist[0] <= i_ref;
            for (int k = 1; k < DEPTH - 1; k++) begin
                r_hist[k] <= r_hist[k-1];
            end
            if (r_fill != c_fill_max) begin
                r_fill <= r_fill + AW'(1);
            end
        end
    end

    // Tap 0 is the live reference; tap d reads the pre-shift entry d-1.
    assign w_idx = i_tap_sel - AW'(1);

    always_comb begin
        o_tap_data = i_ref;
        if (i_tap_sel != '0) begin
            o_tap_data = r_hist[w_idx];
        end
    end

    // Unfilled taps never match, so reset contents cannot cause a false lock.
    assign o_tap_valid = (r_fill >= i_tap_sel);

endmodule
`default_nettype wire

// File: rtl/variable_delay_estimator.sv
`default_nettype none
// ============================================================================
// Module      : variable_delay_estimator
// Description : Recovers the strobe delay between a reference and delayed stream.
// Revision    : 1.0 - initial release
// ============================================================================
module variable_delay_estimator
    import variable_delay_estimator_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               DEPTH        = 32,
    parameter logic [WIDTH-1:0] DEFAULT_DATA = '0,
    parameter int               LOCK_COUNT   = 8,
    parameter int               UNLOCK_COUNT = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clk_en,
    input  logic                          stb_in,
    input  logic [WIDTH-1:0]              ref_in,
    input  logic [WIDTH-1:0]              dly_in,
    input  logic                          restart,
    output logic                          searching,
    output logic                          locked,
    output logic [delay_width(DEPTH)-1:0] delay_out,
    output logic                          lost
);

    localparam int c_aw = delay_width(DEPTH);
    localparam int c_mw = $clog2(LOCK_COUNT + 1);
    localparam int c_uw = $clog2(UNLOCK_COUNT + 1);

    state_t            r_state, w_state_nxt;
    logic [c_aw-1:0]   r_cand, w_cand_nxt;
    logic [c_aw-1:0]   r_delay, w_delay_nxt;
    logic [c_mw-1:0]   r_match_cnt, w_match_cnt_nxt;
    logic [c_uw-1:0]   r_miss_cnt, w_miss_cnt_nxt;
    logic              r_lost, w_lost_nxt;

    logic              w_event;
    logic [c_aw-1:0]   w_tap_sel;
    logic [WIDTH-1:0]  w_tap_data;
    logic              w_tap_valid;
    logic              w_match;

    assign w_event   = clk_en & stb_in;
    assign w_tap_sel = (r_state == LOCKED) ? r_delay : r_cand;
    assign w_match   = w_tap_valid && (dly_in == w_tap_data);

    delay_history_buf #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .DEFAULT_DATA (DEFAULT_DATA)
    ) u_hist (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_shift_en  (w_event),
        .i_ref       (ref_in),
        .i_tap_sel   (w_tap_sel),
        .o_tap_data  (w_tap_data),
        .o_tap_valid (w_tap_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= SEARCH;
            r_cand      <= '0;
            r_delay     <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_lost      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_delay     <= w_delay_nxt;
            r_match_cnt <= w_match_cnt_nxt;
            r_miss_cnt  <= w_miss_cnt_nxt;
            r_lost      <= w_lost_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cand_nxt      = r_cand;
        w_delay_nxt     = r_delay;
        w_match_cnt_nxt = r_match_cnt;
        w_miss_cnt_nxt  = r_miss_cnt;
        w_lost_nxt      = 1'b0;

        // Restart overrides any same-cycle decision; the history still shifts.
        if (clk_en && restart) begin
            w_state_nxt     = SEARCH;
            w_cand_nxt      = '0;
            w_match_cnt_nxt = '0;
            w_miss_cnt_nxt  = '0;
        end else if (w_event) begin
            case (r_state)
                SEARCH: begin
                    if (w_match) begin
                        if (r_match_cnt == c_mw'(LOCK_COUNT - 1)) begin
                            w_state_nxt     = LOCKED;
                            w_delay_nxt     = r_cand;
                            w_miss_cnt_nxt  = '0;
                            w_match_cnt_nxt = '0;
                        end else begin
                            w_match_cnt_nxt = r_match_cnt + c_mw'(1);
                        end
                    end else begin
                        w_match_cnt_nxt = '0;
                        w_cand_nxt      = (r_cand == c_aw'(DEPTH - 1)) ? '0
                                                                       : r_cand + c_aw'(1);
                    end
                end
                LOCKED: begin
                    if (w_match) begin
                        w_miss_cnt_nxt = '0;
                    end else if (r_miss_cnt == c_uw'(UNLOCK_COUNT - 1)) begin
                        w_state_nxt     = SEARCH;
                        w_cand_nxt      = '0;
                        w_match_cnt_nxt = '0;
                        w_miss_cnt_nxt  = '0;
                        w_lost_nxt      = 1'b1;
                    end else begin
                        w_miss_cnt_nxt = r_miss_cnt + c_uw'(1);
                    end
                end
                default: w_state_nxt = SEARCH;
            endcase
        end
    end

    assign searching = (r_state == SEARCH);
    assign locked    = (r_state == LOCKED);
    assign delay_out = r_delay;
    assign lost      = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_variable_delay_estimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_variable_delay_estimator
// Description : Directed self-checking bench for variable_delay_estimator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_variable_delay_estimator;

    logic        clk;
    logic        reset_n;
    logic        clk_en;
    logic        stb_in;
    logic [31:0] ref_in;
    logic [31:0] dly_in;
    logic        restart;
    logic        searching;
    logic        locked;
    logic [4:0]  delay_out;
    logic        lost;

    int passed = 0;
    int total  = 0;
    int ref_val = 1;

    variable_delay_estimator #(
        .WIDTH        (32),
        .DEPTH        (32),
        .DEFAULT_DATA (32'h0),
        .LOCK_COUNT   (8),
        .UNLOCK_COUNT (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_en    (clk_en),
        .stb_in    (stb_in),
        .ref_in    (ref_in),
        .dly_in    (dly_in),
        .restart   (restart),
        .searching (searching),
        .locked    (locked),
        .delay_out (delay_out),
        .lost      (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic s, input logic l,
                             input logic [4:0] d, input logic lo);
        chk({tag, ".searching"}, 64'(searching), 64'(s));
        chk({tag, ".locked"},    64'(locked),    64'(l));
        chk({tag, ".delay_out"}, 64'(delay_out), 64'(d));
        chk({tag, ".lost"},      64'(lost),      64'(lo));
    endtask

    // One event: reference counter plus its copy delayed by d strobes.
    task automatic strobe(input int d, input bit bad);
        ref_in = ref_val;
        dly_in = (ref_val > d) ? 32'(ref_val - d) : 32'h0;
        if (bad) dly_in = dly_in ^ 32'h8000_0000;
        stb_in = 1'b1;
        @(posedge clk);
        #1;
        stb_in = 1'b0;
        ref_val++;
    endtask

    task automatic strobes(input int n, input int d);
        for (int i = 0; i < n; i++) strobe(d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic en_low_strobe();
        clk_en = 1'b0;
        stb_in = 1'b1;
        ref_in = $urandom;
        dly_in = $urandom;
        @(posedge clk);
        #1;
        stb_in = 1'b0;
        clk_en = 1'b1;
    endtask

    task automatic restart_pulse();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
    endtask

    initial begin
        int dev;
        reset_n = 1'b1;
        clk_en  = 1'b1;
        stb_in  = 1'b0;
        ref_in  = '0;
        dly_in  = '0;
        restart = 1'b0;
        #1;

        // Reset and quiet hold
        do_reset();
        chk_state("reset", 1'b1, 1'b0, 5'd0, 1'b0);
        dev = 0;
        for (int i = 0; i < 100; i++) begin
            idle(1);
            if (searching !== 1'b1 || locked !== 1'b0 || delay_out !== 5'd0 || lost !== 1'b0)
                dev++;
        end
        chk("reset_hold_deviations", 64'(dev), 64'd0);

        // Basic lock at delay 5: 5 mismatches then 8 matches
        strobes(12, 5);
        chk("lock5_before", 64'(locked), 64'd0);
        strobe(5, 1'b0);
        chk_state("lock5", 1'b0, 1'b1, 5'd5, 1'b0);

        // Glitch tolerance
        strobe(5, 1'b1);
        chk_state("glitch1", 1'b0, 1'b1, 5'd5, 1'b0);
        strobe(5, 1'b0);
        strobe(5, 1'b1);
        strobe(5, 1'b1);
        strobe(5, 1'b1);
        chk_state("glitch3", 1'b0, 1'b1, 5'd5, 1'b0);
        strobe(5, 1'b0);
        for (int i = 0; i < 3; i++) strobe(5, 1'b1);
        chk("glitch4_pre_locked", 64'(locked), 64'd1);
        strobe(5, 1'b1);
        chk_state("glitch4_lost", 1'b1, 1'b0, 5'd5, 1'b1);
        idle(1);
        chk("lost_one_cycle", 64'(lost), 64'd0);
        strobes(12, 5);
        chk("relock5_before", 64'(locked), 64'd0);
        strobe(5, 1'b0);
        chk_state("relock5", 1'b0, 1'b1, 5'd5, 1'b0);

        // Source delay switches from 5 to 9
        strobes(3, 9);
        chk("switch_3miss_locked", 64'(locked), 64'd1);
        strobe(9, 1'b0);
        chk_state("switch_lost", 1'b1, 1'b0, 5'd5, 1'b1);
        strobes(16, 9);
        chk("lock9_before", 64'(locked), 64'd0);
        chk("lock9_lost_cleared", 64'(lost), 64'd0);
        strobe(9, 1'b0);
        chk_state("lock9", 1'b0, 1'b1, 5'd9, 1'b0);

        // Restart while locked: no lost pulse, same delay recovered
        restart_pulse();
        chk_state("restart", 1'b1, 1'b0, 5'd9, 1'b0);
        strobes(16, 9);
        chk("restart_relock_before", 64'(locked), 64'd0);
        strobe(9, 1'b0);
        chk_state("restart_relock", 1'b0, 1'b1, 5'd9, 1'b0);

        // Gaps and clk_en-low cycles must not change the strobe count to lock
        restart_pulse();
        for (int i = 0; i < 17; i++) begin
            idle($urandom_range(0, 2));
            if (i % 4 == 1) en_low_strobe();
            strobe(9, 1'b0);
            if (i == 15) chk("gaps_before", 64'(locked), 64'd0);
        end
        chk_state("gaps_lock", 1'b0, 1'b1, 5'd9, 1'b0);

        // Asynchronous reset mid-lock, with clk_en low
        #2;
        clk_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_state("async_reset", 1'b1, 1'b0, 5'd0, 1'b0);
        idle(2);
        reset_n = 1'b1;
        clk_en  = 1'b1;
        idle(1);

        // Boundary: delay 0 locks after 8 strobes
        strobes(7, 0);
        chk("lock0_before", 64'(locked), 64'd0);
        strobe(0, 1'b0);
        chk_state("lock0", 1'b0, 1'b1, 5'd0, 1'b0);

        // Boundary: delay 31 locks after 31 mismatches and 8 matches
        do_reset();
        strobes(38, 31);
        chk("lock31_before", 64'(locked), 64'd0);
        strobe(31, 1'b0);
        chk_state("lock31", 1'b0, 1'b1, 5'd31, 1'b0);

        // Delay 32 is out of range: cand wraps and lock never occurs
        do_reset();
        strobes(31, 32);
        chk("cand_at_31", 64'(dut.r_cand), 64'd31);
        strobe(32, 1'b0);
        chk("cand_wrapped", 64'(dut.r_cand), 64'd0);
        dev = 0;
        for (int i = 0; i < 64; i++) begin
            strobe(32, 1'b0);
            if (locked !== 1'b0 || searching !== 1'b1) dev++;
        end
        chk("delay32_never_locks", 64'(dev), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
